// File: rtl/vad_mac_pkg.sv
// rtl/vad_mac_pkg.sv - shared constants, activation codes and FSM state type for the mac feeder
package vad_mac_pkg;
    localparam int N_ACT   = 108;
    localparam int LANES   = 3;
    localparam int DW      = 2;
    localparam int OW      = 10;
    localparam int DONE_TO = 64;
    localparam int N_BEATS = N_ACT / LANES;
    localparam int AW      = 7;
    localparam int BW      = 6;
    localparam int TW      = $clog2(DONE_TO);

    localparam logic [DW-1:0] ACT_POS  = 2'b01;
    localparam logic [DW-1:0] ACT_NEG  = 2'b11;
    localparam logic [DW-1:0] ACT_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_HOLD
    } state_e;

    // The unused code 2'b10 must never reach the mac, it is flattened to zero
    function automatic logic [DW-1:0] act_sanitize(input logic [DW-1:0] code);
        return (code == 2'b10) ? ACT_ZERO : code;
    endfunction
endpackage

// File: rtl/mac_act_feeder_if.sv
// rtl/mac_act_feeder_if.sv - mac beat bus plus result valid/ready port of the feeder
interface mac_act_feeder_if;
    import vad_mac_pkg::*;

    logic [LANES*DW-1:0] mac_in;
    logic                mac_vld;
    logic [OW-1:0]       mac_out1;
    logic [OW-1:0]       mac_out2;
    logic                mac_done;
    logic                res_valid;
    logic                res_ready;
    logic [OW-1:0]       res1;
    logic [OW-1:0]       res2;

    modport master (
        output mac_in, mac_vld, res_valid, res1, res2,
        input  mac_out1, mac_out2, mac_done, res_ready
    );

    modport slave (
        input  mac_in, mac_vld, res_valid, res1, res2,
        output mac_out1, mac_out2, mac_done, res_ready
    );
endinterface

// File: rtl/act_buf.sv
// rtl/act_buf.sv - activation register file with one write port and one beat-wide read port
module act_buf
    import vad_mac_pkg::*;
(
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DW-1:0]       wdata_i,
    input  logic [BW-1:0]       beat_i,
    output logic [LANES*DW-1:0] beat_o
);
    logic [DW-1:0] mem_q [N_ACT];
    logic [AW:0]   idx;
    logic [DW-1:0] val;

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < AW'(N_ACT))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through read so a write issued alongside start is part of beat 0
    always_comb begin
        beat_o = '0;
        idx    = '0;
        val    = ACT_ZERO;
        for (int l = 0; l < LANES; l++) begin
            idx = (AW+1)'(beat_i) * (AW+1)'(LANES) + (AW+1)'(l);
            if (idx < (AW+1)'(N_ACT)) begin
                if (we_i && ({1'b0, waddr_i} == idx)) begin
                    val = wdata_i;
                end else begin
                    val = mem_q[idx[AW-1:0]];
                end
            end else begin
                val = ACT_ZERO;
            end
            beat_o[(LANES-1-l)*DW +: DW] = act_sanitize(val);
        end
    end
endmodule

// File: rtl/mac_act_feeder.sv
// rtl/mac_act_feeder.sv - streams the stored activation vector into the mac and returns its sums
module mac_act_feeder
    import vad_mac_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [DW-1:0]      wr_data_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               err_o,
    mac_act_feeder_if.master   bus
);
    state_e              state_q;
    logic [BW-1:0]       beat_cnt_q;
    logic [TW-1:0]       to_cnt_q;
    logic [LANES*DW-1:0] mac_in_q;
    logic                mac_vld_q;
    logic                res_valid_q;
    logic [OW-1:0]       res1_q;
    logic [OW-1:0]       res2_q;
    logic                err_q;
    logic                buf_we;
    logic [LANES*DW-1:0] beat_data;

    assign buf_we = wr_en_i && (state_q == ST_IDLE);

    // beat_cnt_q is 0 while idle, so the read port already presents beat 0 at start
    act_buf u_act_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .beat_i  (beat_cnt_q),
        .beat_o  (beat_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            to_cnt_q    <= '0;
            mac_in_q    <= '0;
            mac_vld_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res1_q      <= '0;
            res2_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            if (bus.mac_done && (state_q != ST_WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_STREAM;
                        mac_in_q   <= beat_data;
                        mac_vld_q  <= 1'b1;
                        beat_cnt_q <= BW'(1);
                    end
                end
                ST_STREAM: begin
                    if (beat_cnt_q == BW'(N_BEATS)) begin
                        state_q    <= ST_WAIT;
                        mac_in_q   <= '0;
                        mac_vld_q  <= 1'b0;
                        beat_cnt_q <= '0;
                        to_cnt_q   <= '0;
                    end else begin
                        mac_in_q   <= beat_data;
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.mac_done) begin
                        state_q     <= ST_HOLD;
                        res1_q      <= bus.mac_out1;
                        res2_q      <= bus.mac_out2;
                        res_valid_q <= 1'b1;
                    end else if (to_cnt_q == TW'(DONE_TO - 1)) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign err_o         = err_q;
    assign bus.mac_in    = mac_in_q;
    assign bus.mac_vld   = mac_vld_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res1      = res1_q;
    assign bus.res2      = res2_q;
endmodule

// File: tb/tb_mac_act_feeder.sv
// tb/tb_mac_act_feeder.sv - randomized self-checking bench for mac_act_feeder
module tb_mac_act_feeder;
    import vad_mac_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          err;

    mac_act_feeder_if bus();

    mac_act_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .start_i   (start),
        .busy_o    (busy),
        .err_o     (err),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_act [N_ACT];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        if (v > 0) return 2'b01;
        if (v < 0) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int dec(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] exp_beat(input int k);
        return {enc(ref_act[3*k]), enc(ref_act[3*k+1]), enc(ref_act[3*k+2])};
    endfunction

    function automatic int ref_sum();
        int s = 0;
        for (int i = 0; i < N_ACT; i++) s += ref_act[i];
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_act(input int addr, input logic [1:0] code);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = code;
        if (addr < N_ACT) ref_act[addr] = dec(code);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N_ACT; i++) begin
            if (mode == 0)      write_act(i, 2'b00);
            else if (mode == 1) write_act(i, 2'b01);
            else                write_act(i, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic run(input int lat, input int hold, input bit wr_with_start,
                       input bit wr_in_stream, input bit give_done);
        int s_obs;
        int s_ref;
        int vld_cnt;
        int a;
        bit stable;
        logic [1:0] code;
        logic [OW-1:0] e1, e2;
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);
        start = 1'b1;
        if (wr_with_start) begin
            a    = $urandom_range(0, 8);
            code = 2'($urandom_range(0, 3));
            wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = code;
            ref_act[a] = dec(code);
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        s_ref = ref_sum();
        s_obs = 0;
        vld_cnt = 0;
        for (int k = 0; k < N_BEATS; k++) begin
            check_eq($sformatf("beat%0d", k), bus.mac_in, exp_beat(k));
            if (bus.mac_vld) vld_cnt++;
            for (int l = 0; l < LANES; l++) s_obs += dec(bus.mac_in[(LANES-1-l)*DW +: DW]);
            wr_en = 1'b0;
            start = 1'b0;
            if (wr_in_stream && k == 10) begin
                wr_en = 1'b1; wr_addr = 7'd5; wr_data = enc(-ref_act[5]) ^ 2'b10;
            end
            if (k == 15) start = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
        check_eq("vld_len", vld_cnt, N_BEATS);
        check_eq("vld_after", bus.mac_vld, 1'b0);
        check_eq("mac_in_after", bus.mac_in, '0);
        check_eq("busy_wait", busy, 1'b1);
        if (!give_done) begin
            for (int j = 0; j < 67; j++) begin
                if (j == 60) check_eq("err_early", err, 1'b0);
                @(negedge clk);
            end
            check_eq("to_err", err, 1'b1);
            check_eq("to_busy", busy, 1'b0);
            check_eq("to_res_valid", bus.res_valid, 1'b0);
            return;
        end
        repeat (lat) @(negedge clk);
        check_eq("no_early_valid", bus.res_valid, 1'b0);
        bus.mac_done = 1'b1;
        bus.mac_out1 = OW'(-2 * s_obs);
        bus.mac_out2 = OW'(-3 * s_obs);
        @(negedge clk);
        bus.mac_done = 1'b0;
        bus.mac_out1 = OW'($urandom);
        bus.mac_out2 = OW'($urandom);
        e1 = OW'(-2 * s_ref);
        e2 = OW'(-3 * s_ref);
        check_eq("res_valid", bus.res_valid, 1'b1);
        check_eq("res1", bus.res1, e1);
        check_eq("res2", bus.res2, e2);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!bus.res_valid || bus.res1 !== e1 || bus.res2 !== e2) stable = 1'b0;
        end
        check_eq("hold_stable", stable, 1'b1);
        start = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq("post_hs_valid", bus.res_valid, 1'b0);
        check_eq("post_hs_busy", busy, 1'b0);
        check_eq("post_hs_err", err, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_mac_in"}, bus.mac_in, '0);
        check_eq({tag, "_mac_vld"}, bus.mac_vld, 1'b0);
        check_eq({tag, "_res_valid"}, bus.res_valid, 1'b0);
        check_eq({tag, "_res1"}, bus.res1, '0);
        check_eq({tag, "_res2"}, bus.res2, '0);
        check_eq({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        bus.mac_done  = 1'b0;
        bus.mac_out1  = '0;
        bus.mac_out2  = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < N_ACT; i++) ref_act[i] = 0;
        do_reset();
        check_all_zero("reset");

        fill(1);
        run(3, 10, 1'b0, 1'b0, 1'b1);

        fill(0);
        write_act(0, 2'b01);
        write_act(1, 2'b11);
        write_act(2, 2'b00);
        run(0, 2, 1'b0, 1'b0, 1'b1);

        write_act(120, 2'b01);
        run(5, 1, 1'b0, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            fill(2);
            run($urandom_range(0, 20), $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(7, 3, 1'b0, 1'b0, 1'b1);

        run(0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check_eq("err_cleared", err, 1'b0);

        @(negedge clk);
        bus.mac_done = 1'b1;
        @(negedge clk);
        bus.mac_done = 1'b0;
        check_eq("done_idle_err", err, 1'b1);
        check_eq("done_idle_valid", bus.res_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
